// File: rtl/sbrb_pkg.sv
// Shared types and constants for the Sb/Rb pulse driver.
package sbrb_pkg;

  // Driver sequencing: wait for a command, hold one line low, then recover.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Command encoding on cmd_op.
  localparam logic OP_SET = 1'b1;  // pulse Sb, latch ends up Q=1
  localparam logic OP_CLR = 1'b0;  // pulse Rb, latch ends up Q=0

  // Default timing.
  localparam int unsigned PULSE_CYC_DEF = 4;
  localparam int unsigned GAP_CYC_DEF   = 2;

  // Counter width able to hold the larger of the two reload values without wrapping.
  function automatic int unsigned cnt_width(input int unsigned pulse_cyc,
                                            input int unsigned gap_cyc);
    int unsigned longest;
    longest = (pulse_cyc > gap_cyc) ? pulse_cyc : gap_cyc;
    return $clog2(longest) + 1;
  endfunction

endpackage

// File: rtl/sbrb_pulse_driver_if.sv
// Command handshake between control logic and the Sb/Rb pulse driver.
interface sbrb_pulse_driver_if;
  logic cmd_valid;  // command present
  logic cmd_op;     // 1 = set (pulse Sb), 0 = clear (pulse Rb)
  logic cmd_ready;  // driver can accept a command this cycle

  // Requester side.
  modport master (output cmd_valid, output cmd_op, input cmd_ready);
  // Driver side.
  modport slave  (input cmd_valid, input cmd_op, output cmd_ready);
endinterface

// File: rtl/sbrb_sync2.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sbrb_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sbrb_pulse_driver.sv
// Initiating end of an active-low Sb/Rb latch interface.
// Each accepted command becomes a PULSE_CYC-long low pulse on Sb (set) or
// Rb (clear), followed by GAP_CYC cycles with both lines high. Sb and Rb are
// plain flop outputs and are never both low.
// Build option SBRB_FEEDBACK_CHECK_EN: synchronize Q_fb/NQ_fb and raise a
// sticky err when the latch does not hold the commanded value at the end of
// the recovery gap. Without it the feedback inputs are ignored and err is 0.
module sbrb_pulse_driver
  import sbrb_pkg::*;
#(
  parameter int unsigned PULSE_CYC = PULSE_CYC_DEF,  // >= 1
  parameter int unsigned GAP_CYC   = GAP_CYC_DEF     // >= 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sbrb_pulse_driver_if.slave   cmd,
  output logic                 Sb,
  output logic                 Rb,
  input  logic                 Q_fb,
  input  logic                 NQ_fb,
  output logic                 done,
  output logic                 exp_q,
  output logic                 err
);

  localparam int unsigned CNT_W = cnt_width(PULSE_CYC, GAP_CYC);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYC - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             op, op_n;
  logic             sb_n, rb_n, done_n, exp_q_n, err_n;
  logic             fb_mismatch;

`ifdef SBRB_FEEDBACK_CHECK_EN
  logic q_s, nq_s;

  sbrb_sync2 u_sync_q (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (Q_fb),
    .q     (q_s)
  );

  sbrb_sync2 u_sync_nq (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (NQ_fb),
    .q     (nq_s)
  );

  // The latch should present {Q,NQ} = {op,~op} once the recovery gap ends.
  assign fb_mismatch = ({q_s, nq_s} != {op, ~op});
`else
  logic unused_fb;

  // Feedback is not monitored in this build.
  assign unused_fb   = Q_fb ^ NQ_fb;
  assign fb_mismatch = 1'b0;
`endif

  // Ready is a pure decode of the current state.
  assign cmd.cmd_ready = (state == IDLE);

  // Next-state and next-output decode for the pulse sequencer.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_n = state;
    cnt_n   = cnt;
    op_n    = op;
    sb_n    = Sb;
    rb_n    = Rb;
    done_n  = 1'b0;
    exp_q_n = exp_q;
    err_n   = err;

    unique case (state)
      IDLE: begin
        if (cmd.cmd_valid && cmd.cmd_ready) begin
          op_n    = cmd.cmd_op;
          sb_n    = ~cmd.cmd_op;   // set drives Sb low
          rb_n    = cmd.cmd_op;    // clear drives Rb low
          cnt_n   = PULSE_LOAD;
          state_n = PULSE;
        end
      end

      PULSE: begin
        if (cnt == '0) begin
          sb_n    = 1'b1;
          rb_n    = 1'b1;
          cnt_n   = GAP_LOAD;
          state_n = GAP;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      GAP: begin
        if (cnt == '0) begin
          state_n = IDLE;
          done_n  = 1'b1;
          exp_q_n = op;
          if (fb_mismatch) begin
            err_n = 1'b1;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      default: begin
        sb_n    = 1'b1;
        rb_n    = 1'b1;
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any pulse immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= OP_CLR;
      Sb    <= 1'b1;
      Rb    <= 1'b1;
      done  <= 1'b0;
      exp_q <= 1'b0;
      err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state <= state_n;
      cnt   <= cnt_n;
      op    <= op_n;
      Sb    <= sb_n;
      Rb    <= rb_n;
      done  <= done_n;
      exp_q <= exp_q_n;
      err   <= err_n;
    end
  end

endmodule
